dac_sample_arbiter: RTL and testbench
=====================================

DAC_SAMPLE_ARBITER -- requirements
Module: dac_sample_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, stereo-frame entries held ahead of the I2S DAC; power of two, 4..32.
REQ-002 Parameter SILENCE, default 16'h8000, Uint16 mid-scale output code used when disabled.
REQ-003 clk  input  1  system clock, same clock as the I2S DAC.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  arbiter enable; 0 = flush and output SILENCE.
REQ-006 lrck  input  1  L/R clock from the I2S DAC, treated as asynchronous.
REQ-007 dma_valid  input  1  DMA requester has a stereo frame.
REQ-008 dma_ready  output  1  arbiter accepts the DMA frame this cycle.
REQ-009 dma_left, dma_right  input  16 each  DMA samples, Uint16.
REQ-010 cpu_wr  input  1  single-cycle CPU sample write strobe, no backpressure.
REQ-011 cpu_left, cpu_right  input  16 each  CPU samples, Uint16.
REQ-012 clr_flags  input  1  clears the sticky flags.
REQ-013 left, right  output  16 each  samples to the DAC left/right inputs.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 underrun, overflow  output  1 each  sticky error flags.

Function
REQ-016 The CPU path SHALL own a one-entry holding register: on cpu_wr with the register empty it captures cpu_left/right and sets cpu_pend.
REQ-017 A cpu_wr with cpu_pend set and the held entry not granted in that cycle SHALL drop the new data and set overflow.
REQ-018 Push arbitration SHALL be round-robin between DMA and CPU (cpu_pend), one FIFO push per cycle; a last_grant bit records the winner and resets to CPU.
REQ-019 dma_ready SHALL be registered-state only: enable & !full & (!cpu_pend | last_grant==CPU); a DMA transfer is dma_valid & dma_ready.
REQ-020 The CPU entry SHALL be pushed when cpu_pend & enable & !full & (!dma_valid | last_grant==DMA); cpu_pend clears on push, unless a same-cycle cpu_wr reloads it.
REQ-021 A full FIFO SHALL accept no push, even with a pop in the same cycle.
REQ-022 lrck SHALL pass through a 2-flop synchronizer plus one history flop; a rising edge on the synchronized signal is the pop event.
REQ-023 On a pop event with the FIFO non-empty, left/right SHALL update from the FIFO head one clock after edge detection; the read pointer advances.
REQ-024 On a pop event with the FIFO empty, left/right SHALL hold their previous values and underrun SHALL set.
REQ-025 Simultaneous push and pop SHALL both take effect and leave fifo_level unchanged; a pop on empty with a simultaneous push SHALL count as underrun with no bypass.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; full = level==FIFO_DEPTH, empty = level==0.
REQ-027 enable=0 SHALL flush the FIFO, clear cpu_pend, hold dma_ready low, ignore cpu_wr and force left/right to SILENCE from the next clock.
REQ-028 clr_flags SHALL clear both flags; a same-cycle set condition SHALL win.

Reset
REQ-029 While reset_n=0: left=right=SILENCE, fifo_level=0, dma_ready=0, underrun=overflow=0, cpu_pend=0, last_grant=CPU, synchronizer flops=0.
REQ-030 Reset asserted mid-transfer SHALL abandon all queued and held frames; on release, dma_ready SHALL rise no earlier than the first clock edge after reset_n goes high.

Structure
REQ-031 Shared package dac_pkg SHALL hold SAMPLE_W=16, the SILENCE constant, the default FIFO_DEPTH and a stereo-frame struct {left, right}.
REQ-032 One sub-module, dac_frame_fifo (synchronous FIFO of stereo frames with level, full and empty outputs), SHALL be instantiated; arbitration, lrck sync, output registers and flags stay in the top.

Verification
REQ-033 Reset, enable=1, DMA pushes 3 frames (L=16'h1000+n) -> fifo_level=3; after 3 lrck rising edges left=16'h1002; each update appears 1 clk after the synced edge.
REQ-034 dma_valid held high and cpu_wr every 2 clks -> pushes alternate CPU/DMA; no overflow while the FIFO is not full.
REQ-035 Fill to 8 frames, then cpu_wr twice -> dma_ready=0, the first write is held in cpu_pend, the second sets overflow, fifo_level stays 8.
REQ-036 Empty FIFO, left=16'h1234, lrck rising edge -> left holds 16'h1234 and underrun=1; clr_flags pulse -> underrun=0.
REQ-037 5 frames queued, enable dropped for 1 clk -> fifo_level=0, left=right=16'h8000 next clock; reset_n pulsed mid-DMA burst -> all outputs return to their reset values.

Source files
------------

// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared sample width, silence code, default FIFO depth and
//                the stereo-frame type used by the DAC sample arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    localparam int SAMPLE_W = 16;

    // Mid-scale Uint16 code: the DAC output sits at zero volts
    localparam logic [SAMPLE_W-1:0] DAC_SILENCE = 16'h8000;

    localparam int DAC_FIFO_DEPTH = 8;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } frame_t;

    // Winner of the most recent FIFO push; CPU is the reset value
    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } grant_e;

endpackage : dac_pkg
`default_nettype wire

// File: rtl/dac_frame_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : dac_frame_fifo
//  Description : Synchronous FIFO of stereo frames with occupancy level,
//                full/empty flags and a synchronous flush. The head frame is
//                presented combinationally on rd_frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_frame_fifo
    import dac_pkg::*;
#(
    parameter int DEPTH = DAC_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  frame_t                   wr_frame,
    input  logic                     pop,
    output frame_t                   rd_frame,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int                 PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]     C_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q,  level_d;
    frame_t           mem_q [DEPTH];
    frame_t           mem_d [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign full     = (level_q == C_FULL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign rd_frame = mem_q[rd_ptr_q];

    // Pointer, level and storage updates; a full FIFO refuses pushes even
    // when a pop happens in the same cycle
    always_comb begin
        w_do_push = push & ~full;
        w_do_pop  = pop & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        mem_d     = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = wr_frame;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule : dac_frame_fifo
`default_nettype wire

// File: rtl/dac_sample_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_arbiter
//  Description : Round-robin arbiter feeding stereo frames from a DMA stream
//                and a one-entry CPU holding register into a frame FIFO,
//                drained on each synchronized rising edge of the I2S lrck.
//                Sticky underrun/overflow flags, SILENCE output when disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_arbiter
    import dac_pkg::*;
#(
    parameter int                  FIFO_DEPTH = DAC_FIFO_DEPTH,
    parameter logic [SAMPLE_W-1:0] SILENCE    = DAC_SILENCE
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          lrck,
    input  logic                          dma_valid,
    output logic                          dma_ready,
    input  logic [SAMPLE_W-1:0]           dma_left,
    input  logic [SAMPLE_W-1:0]           dma_right,
    input  logic                          cpu_wr,
    input  logic [SAMPLE_W-1:0]           cpu_left,
    input  logic [SAMPLE_W-1:0]           cpu_right,
    input  logic                          clr_flags,
    output logic [SAMPLE_W-1:0]           left,
    output logic [SAMPLE_W-1:0]           right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          overflow
);

    if ((FIFO_DEPTH < 4) || (FIFO_DEPTH > 32) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("dac_sample_arbiter: FIFO_DEPTH must be a power of two in 4..32");
    end

    // lrck synchronizer and edge history
    logic lrck_s1_q,   lrck_s1_d;
    logic lrck_s2_q,   lrck_s2_d;
    logic lrck_hist_q, lrck_hist_d;

    // Holds dma_ready low until the first clock edge after reset release
    logic rst_done_q,  rst_done_d;

    logic                cpu_pend_q,   cpu_pend_d;
    frame_t              cpu_frame_q,  cpu_frame_d;
    grant_e              last_grant_q, last_grant_d;
    logic [SAMPLE_W-1:0] left_q,       left_d;
    logic [SAMPLE_W-1:0] right_q,      right_d;
    logic                underrun_q,   underrun_d;
    logic                overflow_q,   overflow_d;

    logic   w_fifo_full;
    logic   w_fifo_empty;
    logic   w_dma_ready;
    logic   w_dma_push;
    logic   w_cpu_push;
    logic   w_fifo_push;
    logic   w_pop_evt;
    logic   w_fifo_pop;
    logic   w_underrun_set;
    logic   w_overflow_set;
    frame_t w_push_frame;
    frame_t w_head_frame;

    dac_frame_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (~enable),
        .push     (w_fifo_push),
        .wr_frame (w_push_frame),
        .pop      (w_fifo_pop),
        .rd_frame (w_head_frame),
        .level    (fifo_level),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    // Push arbitration and pop/flag event decode; the two push grants are
    // mutually exclusive by construction of the last_grant terms
    always_comb begin
        w_dma_ready    = rst_done_q & enable & ~w_fifo_full &
                         (~cpu_pend_q | (last_grant_q == GRANT_CPU));
        w_dma_push     = dma_valid & w_dma_ready;
        w_cpu_push     = cpu_pend_q & enable & ~w_fifo_full &
                         (~dma_valid | (last_grant_q == GRANT_DMA));
        w_fifo_push    = w_dma_push | w_cpu_push;
        w_push_frame   = w_cpu_push ? cpu_frame_q : '{left: dma_left, right: dma_right};
        w_pop_evt      = lrck_s2_q & ~lrck_hist_q;
        w_fifo_pop     = enable & w_pop_evt & ~w_fifo_empty;
        w_underrun_set = enable & w_pop_evt & w_fifo_empty;
        w_overflow_set = enable & cpu_wr & cpu_pend_q & ~w_cpu_push;
    end

    // Next-state for holding register, grant history, outputs and flags
    always_comb begin
        lrck_s1_d    = lrck;
        lrck_s2_d    = lrck_s1_q;
        lrck_hist_d  = lrck_s2_q;
        rst_done_d   = 1'b1;
        cpu_pend_d   = cpu_pend_q;
        cpu_frame_d  = cpu_frame_q;
        last_grant_d = last_grant_q;
        left_d       = left_q;
        right_d      = right_q;
        underrun_d   = underrun_q;
        overflow_d   = overflow_q;

        if (w_cpu_push) begin
            last_grant_d = GRANT_CPU;
        end else if (w_dma_push) begin
            last_grant_d = GRANT_DMA;
        end

        if (!enable) begin
            cpu_pend_d = 1'b0;
            left_d     = SILENCE;
            right_d    = SILENCE;
        end else begin
            // A write lands if the register is free or is being vacated now
            if (cpu_wr && (!cpu_pend_q || w_cpu_push)) begin
                cpu_pend_d        = 1'b1;
                cpu_frame_d.left  = cpu_left;
                cpu_frame_d.right = cpu_right;
            end else if (w_cpu_push) begin
                cpu_pend_d = 1'b0;
            end
            if (w_fifo_pop) begin
                left_d  = w_head_frame.left;
                right_d = w_head_frame.right;
            end
        end

        // Set conditions take priority over a same-cycle clear
        if (clr_flags) begin
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
        if (w_underrun_set) begin
            underrun_d = 1'b1;
        end
        if (w_overflow_set) begin
            overflow_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lrck_s1_q    <= 1'b0;
            lrck_s2_q    <= 1'b0;
            lrck_hist_q  <= 1'b0;
            rst_done_q   <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_frame_q  <= '0;
            last_grant_q <= GRANT_CPU;
            left_q       <= SILENCE;
            right_q      <= SILENCE;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            lrck_s1_q    <= lrck_s1_d;
            lrck_s2_q    <= lrck_s2_d;
            lrck_hist_q  <= lrck_hist_d;
            rst_done_q   <= rst_done_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_frame_q  <= cpu_frame_d;
            last_grant_q <= last_grant_d;
            left_q       <= left_d;
            right_q      <= right_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dma_ready = w_dma_ready;
    assign left      = left_q;
    assign right     = right_q;
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule : dac_sample_arbiter
`default_nettype wire

// File: tb/tb_dac_sample_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_sample_arbiter
//  Description : Self-checking bench for dac_sample_arbiter: a queue-based
//                reference model compared every clock, directed scenarios
//                with literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_sample_arbiter;

    localparam int          DEPTH = 8;
    localparam logic [15:0] SIL   = 16'h8000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        lrck;
    logic        dma_valid;
    logic        dma_ready;
    logic [15:0] dma_left, dma_right;
    logic        cpu_wr;
    logic [15:0] cpu_left, cpu_right;
    logic        clr_flags;
    logic [15:0] left, right;
    logic [3:0]  fifo_level;
    logic        underrun, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_sample_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .SILENCE    (SIL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .lrck       (lrck),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_left   (dma_left),
        .dma_right  (dma_right),
        .cpu_wr     (cpu_wr),
        .cpu_left   (cpu_left),
        .cpu_right  (cpu_right),
        .clr_flags  (clr_flags),
        .left       (left),
        .right      (right),
        .fifo_level (fifo_level),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_q[$];        // queued frames {left,right}, head at index 0
    logic        m_pend;
    logic [31:0] m_held;
    logic        m_lg_dma;      // last push winner was DMA
    logic [15:0] m_l, m_r;
    logic        m_und, m_ovf;
    logic        m_run;         // at least one clock edge seen since reset release
    logic [2:0]  m_h;           // lrck as sampled 1, 2 and 3 edges ago

    function automatic logic model_ready();
        return m_run && enable && (m_q.size() != DEPTH) && (!m_pend || !m_lg_dma);
    endfunction

    always @(posedge clk) begin : p_model
        logic full, empty, rdy, dpush, cpush, pevt, und_set, ovf_set;
        if (!reset_n) begin
            m_q.delete();
            m_pend = 1'b0; m_held = '0; m_lg_dma = 1'b0;
            m_l = SIL; m_r = SIL; m_und = 1'b0; m_ovf = 1'b0;
            m_run = 1'b0; m_h = '0;
        end else begin
            full    = (m_q.size() == DEPTH);
            empty   = (m_q.size() == 0);
            rdy     = m_run && enable && !full && (!m_pend || !m_lg_dma);
            dpush   = dma_valid && rdy;
            cpush   = m_pend && enable && !full && (!dma_valid || m_lg_dma);
            pevt    = m_h[1] && !m_h[2];   // lrck rise seen through two sync stages
            und_set = enable && pevt && empty;
            ovf_set = enable && cpu_wr && m_pend && !cpush;
            if (!enable) begin
                m_q.delete();
                m_pend = 1'b0;
                m_l = SIL; m_r = SIL;
            end else begin
                if (pevt && !empty) {m_l, m_r} = m_q.pop_front();
                if (cpush) begin
                    m_q.push_back(m_held); m_lg_dma = 1'b0;
                end else if (dpush) begin
                    m_q.push_back({dma_left, dma_right}); m_lg_dma = 1'b1;
                end
                if (cpu_wr && (!m_pend || cpush)) begin
                    m_held = {cpu_left, cpu_right}; m_pend = 1'b1;
                end else if (cpush) begin
                    m_pend = 1'b0;
                end
            end
            if (clr_flags) begin m_und = 1'b0; m_ovf = 1'b0; end
            if (und_set) m_und = 1'b1;
            if (ovf_set) m_ovf = 1'b1;
            m_run = 1'b1;
            m_h   = {m_h[1:0], lrck};
        end
        #1;
        check("left",      32'(left),       32'(m_l));
        check("right",     32'(right),      32'(m_r));
        check("level",     32'(fifo_level), 32'(m_q.size()));
        check("underrun",  32'(underrun),   32'(m_und));
        check("overflow",  32'(overflow),   32'(m_ovf));
        check("dma_ready", 32'(dma_ready),  32'(model_ready()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic lrck_pulse();
        lrck = 1'b1;
        repeat (4) @(negedge clk);
        lrck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic dma_push(input logic [15:0] l, input logic [15:0] r);
        dma_valid = 1'b1; dma_left = l; dma_right = r;
        @(negedge clk);
        dma_valid = 1'b0;
    endtask

    int lr_cnt;

    initial begin
        reset_n = 1'b1; enable = 1'b0; lrck = 1'b0; dma_valid = 1'b0;
        dma_left = '0; dma_right = '0; cpu_wr = 1'b0; cpu_left = '0;
        cpu_right = '0; clr_flags = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_left",  32'(left),       32'h8000);
        check("rst_right", 32'(right),      32'h8000);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(dma_ready),  32'd0);
        check("rst_flags", 32'({underrun, overflow}), 32'd0);

        // Release: ready must wait for the first edge after release
        reset_n = 1'b1; enable = 1'b1;
        #1 check("ready_before_edge", 32'(dma_ready), 32'd0);
        @(negedge clk);
        check("ready_after_edge", 32'(dma_ready), 32'd1);

        // Three DMA frames then three lrck edges
        for (int n = 0; n < 3; n++) dma_push(16'h1000 + 16'(n), 16'h2000 + 16'(n));
        check("dma3_level", 32'(fifo_level), 32'd3);
        check("dma3_model", 32'(m_q.size()), 32'd3);
        lrck_pulse();
        lrck_pulse();
        lrck = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pop_latency_old", 32'(left), 32'h1001);
        @(negedge clk);
        check("pop3_left",  32'(left),  32'h1002);
        check("pop3_right", 32'(right), 32'h2002);
        lrck = 1'b0;
        repeat (3) @(negedge clk);

        // DMA held valid, CPU write every other clock: pushes alternate
        for (int k = 0; k < 6; k++) begin
            dma_valid = 1'b1; dma_left = 16'h4000 + 16'(k); dma_right = 16'h4100 + 16'(k);
            cpu_wr = (k % 2 == 0); cpu_left = 16'h3000 + 16'(k); cpu_right = 16'h3100 + 16'(k);
            @(negedge clk);
        end
        dma_valid = 1'b0; cpu_wr = 1'b0;
        check("alt_level",    32'(fifo_level), 32'd6);
        check("alt_overflow", 32'(overflow),   32'd0);
        check("alt_q0_dma",   m_q[0],          {16'h4000, 16'h4100});
        check("alt_q1_cpu",   m_q[1],          {16'h3000, 16'h3100});

        // Fill to 8, then two CPU writes against a full FIFO
        dma_push(16'h4A00, 16'h4B00);
        dma_push(16'h4A01, 16'h4B01);
        check("full_level", 32'(fifo_level), 32'd8);
        cpu_wr = 1'b1; cpu_left = 16'h5555; cpu_right = 16'h5556;
        @(negedge clk);
        check("full_pend_no_ovf", 32'(overflow), 32'd0);
        cpu_left = 16'h6666; cpu_right = 16'h6667;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("full_ovf",        32'(overflow),   32'd1);
        check("full_level_hold", 32'(fifo_level), 32'd8);
        check("full_ready",      32'(dma_ready),  32'd0);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Disable for one clock flushes everything
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("flush_level", 32'(fifo_level), 32'd0);
        check("flush_left",  32'(left),       32'h8000);
        check("flush_right", 32'(right),      32'h8000);

        // CPU frame 1234, play it, then underrun on empty FIFO
        cpu_wr = 1'b1; cpu_left = 16'h1234; cpu_right = 16'h5678;
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        check("cpu_level", 32'(fifo_level), 32'd1);
        lrck_pulse();
        check("cpu_left_out",  32'(left),  32'h1234);
        check("cpu_right_out", 32'(right), 32'h5678);
        lrck_pulse();
        check("und_hold_left", 32'(left),     32'h1234);
        check("und_set",       32'(underrun), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("und_cleared", 32'(underrun), 32'd0);

        // Five frames queued, disable for one clock
        for (int n = 0; n < 5; n++) dma_push(16'h7000 + 16'(n), 16'h7100 + 16'(n));
        check("five_level", 32'(fifo_level), 32'd5);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("five_flush_level", 32'(fifo_level), 32'd0);
        check("five_flush_left",  32'(left),       32'h8000);
        check("five_flush_right", 32'(right),      32'h8000);

        // Non-reset state, then reset in the middle of a DMA burst
        dma_push(16'h7777, 16'h8888);
        lrck_pulse();
        lrck_pulse();
        check("pre_rst_left", 32'(left), 32'h7777);
        for (int n = 0; n < 4; n++) begin
            dma_valid = 1'b1; dma_left = 16'h9000 + 16'(n); dma_right = 16'h9100 + 16'(n);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        check("midrst_left",  32'(left),       32'h8000);
        check("midrst_right", 32'(right),      32'h8000);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_ready", 32'(dma_ready),  32'd0);
        check("midrst_flags", 32'({underrun, overflow}), 32'd0);
        @(negedge clk);
        dma_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Randomized traffic: busy phase fills the FIFO, quiet phase starves it
        lr_cnt = 3;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (lr_cnt == 0) begin
                lrck   = ~lrck;
                lr_cnt = (cyc < 2000) ? int'($urandom_range(2, 9)) : int'($urandom_range(1, 3));
            end else begin
                lr_cnt--;
            end
            if (cyc < 2000) begin
                dma_valid = ($urandom_range(0, 1) == 1);
                cpu_wr    = ($urandom_range(0, 3) == 0);
            end else begin
                dma_valid = ($urandom_range(0, 15) == 0);
                cpu_wr    = ($urandom_range(0, 15) == 0);
            end
            dma_left  = 16'($urandom);
            dma_right = 16'($urandom);
            cpu_left  = 16'($urandom);
            cpu_right = 16'($urandom);
            enable    = ($urandom_range(0, 63) != 0);
            clr_flags = ($urandom_range(0, 31) == 0);
            reset_n   = ($urandom_range(0, 999) != 0);
        end
        @(negedge clk);
        reset_n = 1'b1; enable = 1'b1; dma_valid = 1'b0; cpu_wr = 1'b0; clr_flags = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dac_sample_arbiter
`default_nettype wire
